// File: rtl/midi_rx_pkg.sv
// Shared MIDI constants, receiver state encoding and message-length helper.
// The top module's optional behaviour is selected with MIDI_NOTE_OFF_VEL0_EN.
package constants;

    localparam int MIDI_BYTES = 24;
    localparam int MIDI_BAUD  = 31250;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic is_one_data(input logic [3:0] nib);
        return (nib == PROG) || (nib == CHAN_AT);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start/data/stop FSM and mid-bit sampling counter.
// Outputs byte_out with a one-cycle byte_valid_out, or a one-cycle framing_err_out.
module uart_rx_byte
    import constants::*;
#(
    parameter int CYCLES_PER_BIT = 3146
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       byte_valid_out,
    output logic       framing_err_out
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CYCLES_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CYCLES_PER_BIT - 1);

    logic            sync1, sync2, line_prev;
    rx_state_t       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shreg, shreg_next;

    // line_prev resets low so a line held low through reset cannot fake a start edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_prev <= 1'b0;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            sync1     <= rx_in;
            sync2     <= sync1;
            line_prev <= sync2;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shreg     <= shreg_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bit_next        = bit_idx;
        shreg_next      = shreg;
        byte_valid_out  = 1'b0;
        framing_err_out = 1'b0;
        case (state)
            RX_IDLE: begin
                if (line_prev && !sync2) begin
                    state_next = RX_START;
                    cnt_next   = HALF;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (sync2) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next = RX_DATA;
                        cnt_next   = FULL;
                        bit_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shreg_next = {sync2, shreg[7:1]};
                    cnt_next   = FULL;
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_next      = RX_IDLE;
                    byte_valid_out  = sync2;
                    framing_err_out = !sync2;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_out = shreg;

endmodule

// File: rtl/midi_rx.sv
// MIDI receiver top: running-status message parser, channel filter and event output registers.
// Define MIDI_NOTE_OFF_VEL0_EN to report note-on with zero velocity as note-off.
module midi_rx
    import constants::*;
#(
    parameter int         CYCLES_PER_BIT = 3146,
    parameter logic [3:0] MIDI_CHANNEL   = 4'd0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  midi_rx_in,
    output logic [MIDI_BYTES-1:0] midi_event_out,
    output logic                  event_valid_out,
    output logic                  framing_err_out
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       status_valid, for_us, have_d1;
    logic [3:0] status_nib;
    logic [7:0] data1;
    logic [7:0] ev_status, ev_d1, ev_d2;
    logic       msg_done;

    uart_rx_byte #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_rx (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rx_in          (midi_rx_in),
        .byte_out       (rx_byte),
        .byte_valid_out (byte_valid),
        .framing_err_out(framing_err_out)
    );

    assign msg_done = have_d1 || is_one_data(status_nib);

    always_comb begin
        ev_status = {status_nib, 4'h0};
        if (is_one_data(status_nib)) begin
            ev_d1 = rx_byte;
            ev_d2 = 8'h00;
        end else begin
            ev_d1 = data1;
            ev_d2 = rx_byte;
        end
`ifdef MIDI_NOTE_OFF_VEL0_EN
        if (status_nib == NOTE_ON && ev_d2 == 8'h00) begin
            ev_status = {NOTE_OFF, 4'h0};
        end
`endif
    end

    // Real-time bytes (0xF8+) fall through untouched; 0xF0-0xF7 drop running status.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            midi_event_out  <= '0;
            event_valid_out <= 1'b0;
            status_valid    <= 1'b0;
            status_nib      <= '0;
            for_us          <= 1'b0;
            have_d1         <= 1'b0;
            data1           <= '0;
        end else begin
            event_valid_out <= 1'b0;
            if (framing_err_out) begin
                have_d1 <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte[7:4] == 4'hF) begin
                    if (!rx_byte[3]) begin
                        status_valid <= 1'b0;
                        have_d1      <= 1'b0;
                    end
                end else if (rx_byte[7]) begin
                    status_valid <= 1'b1;
                    status_nib   <= rx_byte[7:4];
                    for_us       <= (rx_byte[3:0] == MIDI_CHANNEL);
                    have_d1      <= 1'b0;
                end else if (status_valid) begin
                    if (msg_done) begin
                        have_d1 <= 1'b0;
                        if (for_us) begin
                            midi_event_out  <= {ev_status, ev_d1, ev_d2};
                            event_valid_out <= 1'b1;
                        end
                    end else begin
                        data1   <= rx_byte;
                        have_d1 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx: directed MIDI sequences plus random byte streams,
// a message-level reference model feeding an expected-event queue, and a decoupled monitor.
module tb_midi_rx;
    import constants::*;

    localparam int         CPB = 16;
    localparam logic [3:0] CH  = 4'd0;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  midi_rx_in;
    logic [MIDI_BYTES-1:0] midi_event_out;
    logic                  event_valid_out;
    logic                  framing_err_out;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  pend[$];
    logic [7:0]  rs;
    logic [23:0] last_word;
    int          ferr_exp = 0;
    int          ferr_seen = 0;

    always #5 clk_in = ~clk_in;

    midi_rx #(
        .CYCLES_PER_BIT(CPB),
        .MIDI_CHANNEL  (CH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .midi_rx_in     (midi_rx_in),
        .midi_event_out (midi_event_out),
        .event_valid_out(event_valid_out),
        .framing_err_out(framing_err_out)
    );

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %06h, expected %06h", name, act, req);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: a running status byte plus a queue of collected data bytes.
    task automatic modelByte(input logic [7:0] b, input bit good);
        int need;
        logic [23:0] w;
        if (!good) begin
            pend.delete();
            ferr_exp++;
        end else if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            rs = 8'h00;
            pend.delete();
        end else if (b >= 8'h80) begin
            rs = b;
            pend.delete();
        end else if (rs >= 8'h80) begin
            pend.push_back(b);
            need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
            if (pend.size() == need) begin
                if (need == 2) w = {rs[7:4], 4'h0, pend[0], pend[1]};
                else           w = {rs[7:4], 4'h0, pend[0], 8'h00};
`ifdef MIDI_NOTE_OFF_VEL0_EN
                if (w[23:20] == 4'h9 && w[7:0] == 8'h00) w[23:16] = 8'h80;
`endif
                if (rs[3:0] == CH) begin
                    exp_q.push_back(w);
                    last_word = w;
                end
                pend.delete();
            end
        end
    endtask

    task automatic serialByte(input logic [7:0] b, input bit good);
        midi_rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            midi_rx_in = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        midi_rx_in = good;
        repeat (CPB) @(negedge clk_in);
        if (!good) begin
            midi_rx_in = 1'b1;
            repeat (2 * CPB) @(negedge clk_in);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit good);
        modelByte(b, good);
        serialByte(b, good);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_event"}, midi_event_out, 24'h0);
        checkOutput({tag, "_valid"}, {23'h0, event_valid_out}, 24'h0);
        checkOutput({tag, "_ferr"}, {23'h0, framing_err_out}, 24'h0);
    endtask

    task automatic resetMidByte();
        midi_rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            midi_rx_in = 1'b0;
            repeat (CPB) @(negedge clk_in);
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checkResetState("midreset");
        rst_in = 1'b0;
        rs = 8'h00;
        pend.delete();
        last_word = 24'h0;
        repeat (CPB) @(negedge clk_in);
        midi_rx_in = 1'b1;
        repeat (2 * CPB) @(negedge clk_in);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (event_valid_out) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_event: got %06h, expected no event", midi_event_out);
                end else begin
                    checkOutput("event_word", midi_event_out, exp_q.pop_front());
                end
            end
            if (framing_err_out) ferr_seen++;
        end
    end

    initial begin
        int k;
        logic [7:0] b;
        bit good;
        rs = 8'h00;
        last_word = 24'h0;
        rst_in = 1'b1;
        midi_rx_in = 1'b1;
        repeat (4) @(negedge clk_in);
        checkResetState("reset");
        rst_in = 1'b0;
        repeat (2 * CPB) @(negedge clk_in);

        applyStimulus(8'h90, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h64, 1'b1);

        applyStimulus(8'h90, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h64, 1'b1);

        applyStimulus(8'hB0, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h40, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h7F, 1'b1);

        applyStimulus(8'h90, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hF8, 1'b1);
        applyStimulus(8'h64, 1'b1);

        applyStimulus(8'h91, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h64, 1'b1);
        repeat (4) @(negedge clk_in);
        checkOutput("hold_other_channel", midi_event_out, last_word);

        applyStimulus(8'h90, 1'b1);
        applyStimulus(8'h40, 1'b1);
        applyStimulus(8'h00, 1'b1);

        resetMidByte();
        applyStimulus(8'hC0, 1'b1);
        applyStimulus(8'h05, 1'b1);

        midi_rx_in = 1'b0;
        repeat (3) @(negedge clk_in);
        midi_rx_in = 1'b1;
        repeat (2 * CPB) @(negedge clk_in);
        checkOutput("hold_after_glitch", midi_event_out, last_word);

        for (int n = 0; n < 160; n++) begin
            k = $urandom_range(0, 99);
            if (k < 22)
                b = {1'b1, 3'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0) ? 4'($urandom) : CH};
            else if (k < 27)
                b = 8'hF8 + 8'($urandom_range(0, 7));
            else if (k < 30)
                b = 8'hF0 + 8'($urandom_range(0, 7));
            else
                b = {1'b0, 7'($urandom)};
            good = ($urandom_range(0, 29) != 0);
            applyStimulus(b, good);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk_in);
        checkCount("pending_events", exp_q.size(), 0);
        checkCount("framing_errors", ferr_seen, ferr_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
